// File: rtl/nios_system_vga_cpu_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_vga_cpu_mult_seq
// Brief    : Sequential 32x32 multiplier (MUL/MULXUU/MULXSU/MULXSS) built on
//            one time-shared 16x16 unsigned multiplier.
// Revision : 1.0
// ============================================================================
module nios_system_vga_cpu_mult_seq #(
    parameter int CORR_STAGE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam bit FOLD_CORR = (CORR_STAGE == 0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        CORR = 3'd5,
        FIN  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic [15:0] mul_a, mul_b;
    logic [31:0] prod;
    logic [31:0] corr;
    logic        accept;

    // The only multiplier in the design; operand halves are steered per state.
    assign prod = mul_a * mul_b;

    // Signed-operand fix-up of the unsigned high word, modulo 2^32.
    assign corr = ((op_q[1] && src1_q[31]) ? src2_q : 32'd0)
                + (((op_q == 2'd3) && src2_q[31]) ? src1_q : 32'd0);

    assign busy   = (state_q != IDLE) && (state_q != FIN);
    assign done   = done_q;
    assign result = result_q;
    assign accept = start && !flush && !busy;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        mul_a    = src1_q[15:0];
        mul_b    = src2_q[15:0];

        unique case (state_q)
            IDLE: ;
            P0: begin
                acc_d   = acc_q + {32'd0, prod};
                state_d = P1;
            end
            P1: begin
                mul_b   = src2_q[31:16];
                acc_d   = acc_q + ({32'd0, prod} << 16);
                state_d = P2;
            end
            P2: begin
                mul_a   = src1_q[31:16];
                acc_d   = acc_q + ({32'd0, prod} << 16);
                state_d = P3;
            end
            P3: begin
                mul_a = src1_q[31:16];
                mul_b = src2_q[31:16];
                if (FOLD_CORR) begin
                    acc_d   = acc_q + {prod, 32'd0} - {corr, 32'd0};
                    state_d = FIN;
                end else begin
                    acc_d   = acc_q + {prod, 32'd0};
                    state_d = CORR;
                end
            end
            CORR: begin
                acc_d   = acc_q - {corr, 32'd0};
                state_d = FIN;
            end
            FIN: begin
                done_d   = 1'b1;
                result_d = (op_q == 2'd0) ? acc_q[31:0] : acc_q[63:32];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // FIN already produced its result above, so a new op may start here.
        if (accept) begin
            op_d    = op;
            src1_d  = src1;
            src2_d  = src2;
            acc_d   = 64'd0;
            state_d = P0;
        end

        if (flush && busy) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            src1_q   <= 32'd0;
            src2_q   <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_vga_cpu_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_vga_cpu_mult_seq
// Brief    : Bench for both correction-stage variants against a 64-bit model.
// Revision : 1.0
// ============================================================================
module tb_nios_system_vga_cpu_mult_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic        flush;
    logic        busy1, done1, busy0, done0;
    logic [31:0] result1, result0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nios_system_vga_cpu_mult_seq #(.CORR_STAGE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src1(src1),
        .src2(src2), .flush(flush), .busy(busy1), .done(done1), .result(result1)
    );

    nios_system_vga_cpu_mult_seq #(.CORR_STAGE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src1(src1),
        .src2(src2), .flush(flush), .busy(busy0), .done(done0), .result(result0)
    );

    // Full 64-bit product of the operands, each extended as the op dictates.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o >= 2'd2 && a[31]) ? {32'hFFFF_FFFF, a} : {32'd0, a};
        eb = (o == 2'd3 && b[31]) ? {32'hFFFF_FFFF, b} : {32'd0, b};
        p  = ea * eb;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op to both variants and check latency, single done and value.
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
        logic [31:0] e;
        logic [31:0] r1, r0;
        int lat1, lat0, n1, n0;
        e = model(o, a, b);
        lat1 = 0; lat0 = 0; n1 = 0; n0 = 0; r1 = 'x; r0 = 'x;
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 'x; src1 = 'x; src2 = 'x;
        chk({tag, "_busy"}, 32'(busy1), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done1) begin n1++; if (lat1 == 0) lat1 = k; r1 = result1; end
            if (done0) begin n0++; if (lat0 == 0) lat0 = k; r0 = result0; end
        end
        chk({tag, "_lat1"}, 32'(lat1), 32'd6);
        chk({tag, "_lat0"}, 32'(lat0), 32'd5);
        chk({tag, "_ndone1"}, 32'(n1), 32'd1);
        chk({tag, "_ndone0"}, 32'(n0), 32'd1);
        chk({tag, "_res1"}, r1, e);
        chk({tag, "_res0"}, r0, e);
        chk({tag, "_hold1"}, result1, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prev;
        int n1, n0, lat;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 'x; src1 = 'x; src2 = 'x;
        #23;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_result1", result1, 32'd0);
        chk("rst_result0", result0, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // First start after reset, basic low word.
        run(2'd0, 32'h0001_0002, 32'h0003_0004, "mul");
        chk("mul_const", result1, 32'h000A_0008);

        // MULXUU then back-to-back MULXSS issued in the FIN cycle.
        @(negedge clk);
        start = 1'b1; op = 2'd1; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk); #1;
        chk("b2b_fin_busy", 32'(busy1), 32'd0);
        start = 1'b1; op = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done1", 32'(done1), 32'd1);
        chk("b2b_res1", result1, 32'hFFFF_FFFE);
        chk("b2b_busy_again", 32'(busy1), 32'd1);
        n1 = 0; lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done1) begin n1++; if (lat == 0) lat = k; end
        end
        chk("b2b_lat", 32'(lat), 32'd6);
        chk("b2b_ndone", 32'(n1), 32'd1);
        chk("b2b_res2", result1, model(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF));

        // Signed corners.
        run(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulxsu_m1");
        chk("mulxsu_const", result1, 32'hFFFF_FFFF);
        run(2'd3, 32'h8000_0000, 32'h8000_0000, "mulxss_min");
        chk("mulxss_const", result1, 32'h4000_0000);

        // Random operands, with sign bits biased to exercise the correction.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if (i[0]) a[31] = 1'b1;
            if (i[1]) b[31] = 1'b1;
            run(2'($urandom_range(0, 3)), a, b, $sformatf("rnd%0d", i));
        end

        // Flush in P2: no done, busy drops, result unchanged.
        prev = result1;
        @(negedge clk);
        start = 1'b1; op = 2'd0; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy1", 32'(busy1), 32'd0);
        chk("flush_busy0", 32'(busy0), 32'd0);
        n1 = 0; n0 = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done1) n1++;
            if (done0) n0++;
        end
        chk("flush_ndone1", 32'(n1), 32'd0);
        chk("flush_ndone0", 32'(n0), 32'd0);
        chk("flush_res1", result1, prev);

        // Start pulsed while busy is dropped, not queued.
        @(negedge clk);
        start = 1'b1; op = 2'd1; src1 = 32'hDEAD_BEEF; src2 = 32'h0BAD_F00D;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; src1 = 32'd3; src2 = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        n1 = 0; n0 = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done1) n1++;
            if (done0) n0++;
        end
        chk("ign_ndone1", 32'(n1), 32'd1);
        chk("ign_ndone0", 32'(n0), 32'd1);
        chk("ign_res1", result1, model(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D));

        // Asynchronous reset during P1.
        @(negedge clk);
        start = 1'b1; op = 2'd0; src1 = 32'h0000_1111; src2 = 32'h0000_2222;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_done", 32'(done1), 32'd0);
        chk("arst_res", result1, 32'd0);
        @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done1 || done0) n1++;
        end
        chk("arst_ndone", 32'(n1), 32'd0);
        run(2'd0, 32'd7, 32'd9, "post_rst");
        chk("post_rst_const", result1, 32'h0000_003F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_system_vga_cpu_mult_seq.md
NIOS_SYSTEM_VGA_CPU_MULT_SEQ -- requirements
Module: nios_system_vga_cpu_mult_seq

Interface
REQ-001 The block SHALL have parameter CORR_STAGE, default 1, meaning 1 = separate signed-correction cycle (latency 6) and 0 = correction folded into the last partial-product cycle (latency 5).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  request; accepted on a rising edge where start=1 and busy=0.
REQ-005 The block SHALL have port op  input  2  operation: 0 MUL (low word), 1 MULXUU, 2 MULXSU (src1 signed, src2 unsigned), 3 MULXSS; ops 1-3 return the high word.
REQ-006 The block SHALL have ports src1 and src2  input  32  operands, sampled only on the accepting edge.
REQ-007 The block SHALL have port flush  input  1  synchronous abort.
REQ-008 The block SHALL have port busy  output  1  operation in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 The block SHALL have port result  output  32  product word, held until the next done.

Function
REQ-011 The block SHALL use a single unsigned 16x16->32 multiplier, time-shared across cycles.
REQ-012 The FSM SHALL have states IDLE, P0, P1, P2, P3, CORR (present only when CORR_STAGE=1), and FIN.
REQ-013 On an accepting edge, the block SHALL latch op, src1 and src2, clear the 64-bit accumulator, enter P0, and set busy=1.
REQ-014 The partial products SHALL be added to the accumulator as follows:
- P0: src1[15:0]*src2[15:0] at shift 0
- P1: src1[15:0]*src2[31:16] at shift 16
- P2: src1[31:16]*src2[15:0] at shift 16
- P3: src1[31:16]*src2[31:16] at shift 32
REQ-015 Signed correction, applied in CORR (or in P3 when CORR_STAGE=0), SHALL consist of:
- op 2 or 3 with src1[31]=1: subtract src2 from acc[63:32]
- op 3 with src2[31]=1: subtract src1 from acc[63:32]
- all arithmetic modulo 2^64
REQ-016 In FIN, result SHALL be acc[31:0] for op 0 and acc[63:32] otherwise; done=1 and busy=0 for exactly one cycle; the FSM then returns to IDLE.
REQ-017 Latency SHALL be fixed and data-independent: done rises 6 edges (CORR_STAGE=1) or 5 edges (CORR_STAGE=0) after the accepting edge.
REQ-018 A start asserted in the FIN cycle SHALL be accepted (back-to-back issue); a start asserted while busy=1 SHALL be ignored and not queued.
REQ-019 Flush=1 on any edge with busy=1 SHALL return the FSM to IDLE with no done pulse and result unchanged.
REQ-020 If flush and start are both 1 while in IDLE or FIN, flush SHALL win and start SHALL be ignored.
REQ-021 The block SHALL produce no outputs of X from an X on op or src while busy=0.

Reset
REQ-022 While reset_n=0, the block SHALL set state=IDLE, busy=0, done=0, result=0x00000000, and accumulator=0, asynchronously and regardless of clk.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse after release.
REQ-024 The first start after reset release SHALL be accepted on the first clk edge at which start=1.

Verification
REQ-025 MUL: op=0, src1=0x00010002, src2=0x00030004 -> done after 6 edges, result=0x000A0008.
REQ-026 MULXUU/MULXSS: op=1, src1=src2=0xFFFFFFFF -> result=0xFFFFFFFE; then back-to-back op=3 with the same operands issued in the FIN cycle -> result=0x00000000, done exactly 6 edges later.
REQ-027 MULXSU and MULXSS corner: op=2, src1=src2=0xFFFFFFFF -> result=0xFFFFFFFF; op=3, src1=src2=0x80000000 -> result=0x40000000.
REQ-028 Flush and ignored start: start, then flush at P2 -> no done, busy=0 on the next cycle, result keeps its previous value; a start pulsed while busy=1 -> no second done.
REQ-029 Reset mid-op: reset_n low during P1 -> outputs 0 immediately; after release, a new op=0 with 7*9 -> result=0x0000003F.
REQ-030 CORR_STAGE=0: repeat REQ-025 and REQ-027 -> identical results with done after 5 edges.
